// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM, command and constant definitions for mem_port_arbiter
package mem_arb_pkg;

  // Widths of the latched command; the top-level ADDR_W/DATA_W defaults follow these
  localparam int ARB_ADDR_W = 25;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  localparam logic [1:0] OPLEN_B = 2'd0;
  localparam logic [1:0] OPLEN_H = 2'd1;
  localparam logic [1:0] OPLEN_W = 2'd2;

  typedef struct packed {
    logic                  rw;
    logic [1:0]            oplen;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic                  is_data;
  } mem_cmd_t;

  // Read data returned alongside err when a transaction times out
  localparam logic [ARB_DATA_W-1:0] ERR_RDATA = '0;

  // Instruction fetches are always word reads with no store data
  function automatic mem_cmd_t instr_cmd(input logic [ARB_ADDR_W-1:0] addr);
    mem_cmd_t c;
    c.rw      = 1'b0;
    c.oplen   = OPLEN_W;
    c.addr    = addr;
    c.wdata   = '0;
    c.is_data = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// rtl/arb_grant_sel.sv - winner select with ack masks and data-streak fairness (macro ARB_FAIR_EN)
module arb_grant_sel
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W        = 3
) (
  input  logic                  i_req,
  input  logic                  i_ack,
  input  logic [ARB_ADDR_W-1:0] i_addr,
  input  logic                  d_req,
  input  logic                  d_ack,
  input  logic                  d_rw,
  input  logic [1:0]            d_oplen,
  input  logic [ARB_ADDR_W-1:0] d_addr,
  input  logic [ARB_DATA_W-1:0] d_wdata,
  input  logic [STREAK_W-1:0]   streak_q,
  output logic                  sel_valid,
  output mem_cmd_t              sel_cmd,
  output logic [STREAK_W-1:0]   streak_d
);

  logic i_elig;
  logic d_elig;
  logic turnaround;
  logic force_i;
  logic pick_d;

  // Eligibility, winner choice and the next streak count for this grant
  always_comb begin
    i_elig     = i_req & ~i_ack;
    d_elig     = d_req & ~d_ack;
    // The ack cycle grants nothing, so the other port cannot leapfrog a
    // requester whose req is still high only because it just got its ack.
    turnaround = i_ack | d_ack;
`ifdef ARB_FAIR_EN
    force_i    = i_elig && (streak_q == STREAK_W'(MAX_DATA_STREAK));
`else
    force_i    = 1'b0;
`endif
    pick_d     = d_elig & ~force_i;
    sel_valid  = (i_elig | d_elig) & ~turnaround;

    if (pick_d) begin
      sel_cmd.rw      = d_rw;
      sel_cmd.oplen   = d_oplen;
      sel_cmd.addr    = d_addr;
      sel_cmd.wdata   = d_wdata;
      sel_cmd.is_data = 1'b1;
    end else begin
      sel_cmd = instr_cmd(i_addr);
    end

    // Streak grows only for data grants that leave instr waiting; it is
    // kept in both builds, but only the fair build acts on it.
    streak_d = '0;
    if (pick_d && i_elig) begin
      if (streak_q == STREAK_W'(MAX_DATA_STREAK)) begin
        streak_d = streak_q;
      end else begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/LSU arbiter for the single SDRAM controller port (fairness via ARB_FAIR_EN)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = ARB_ADDR_W,
  parameter int DATA_W          = ARB_DATA_W,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_oplen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              mem_enable,
  input  logic              mem_ready,
  output logic              mem_is_data,
  output logic              mem_rw,
  output logic [1:0]        mem_oplen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  arb_state_t           state_q;
  arb_state_t           state_d;
  mem_cmd_t             cmd_q;
  mem_cmd_t             sel_cmd;
  logic                 sel_valid;
  logic [STREAK_W-1:0]  streak_q;
  logic [STREAK_W-1:0]  streak_d;
  logic                 seen_low_q;
  logic [TO_W-1:0]      tcnt_q;
  logic                 do_grant;
  logic                 do_done;
  logic                 do_timeout;

  arb_grant_sel #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK),
    .STREAK_W        (STREAK_W)
  ) u_grant_sel (
    .i_req     (i_req),
    .i_ack     (i_ack),
    .i_addr    (i_addr),
    .d_req     (d_req),
    .d_ack     (d_ack),
    .d_rw      (d_rw),
    .d_oplen   (d_oplen),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .streak_q  (streak_q),
    .sel_valid (sel_valid),
    .sel_cmd   (sel_cmd),
    .streak_d  (streak_d)
  );

  assign mem_is_data = cmd_q.is_data;
  assign mem_rw      = cmd_q.rw;
  assign mem_oplen   = cmd_q.oplen;
  assign mem_addr    = cmd_q.addr;
  assign mem_wdata   = cmd_q.wdata;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_grant) state_d = ISSUE;
      ISSUE:   state_d = BUSY;
      BUSY:    if (do_done || do_timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: command strobe plus grant/completion/timeout events
  always_comb begin
    mem_enable = 1'b0;
    do_grant   = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    case (state_q)
      IDLE:  do_grant = mem_ready && sel_valid;
      ISSUE: mem_enable = 1'b1;
      BUSY: begin
        // A controller that only just dropped ready has not finished yet,
        // so completion needs ready to have been seen low first.
        do_done    = mem_ready && seen_low_q;
        do_timeout = !do_done && (tcnt_q == TO_LAST);
      end
      default: ;
    endcase
  end

  // Command latch, busy tracking, timeout count and ack/rdata return
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q      <= '0;
      streak_q   <= '0;
      seen_low_q <= 1'b0;
      tcnt_q     <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      if (do_grant) begin
        cmd_q    <= sel_cmd;
        streak_q <= streak_d;
      end
      if (state_q == ISSUE) begin
        seen_low_q <= 1'b0;
        tcnt_q     <= '0;
      end
      if (state_q == BUSY) begin
        if (!mem_ready) seen_low_q <= 1'b1;
        if (!do_done && !do_timeout) tcnt_q <= tcnt_q + TO_W'(1);
      end
      if (do_done || do_timeout) begin
        err <= do_timeout;
        if (cmd_q.is_data) begin
          d_ack   <= 1'b1;
          d_rdata <= do_done ? mem_rdata : ERR_RDATA;
        end else begin
          i_ack   <= 1'b1;
          i_rdata <= do_done ? mem_rdata : ERR_RDATA;
        end
      end
    end
  end

  // A granted requester must keep req high until its ack
  always @(posedge clk) begin
    if (rst_n && state_q != IDLE) begin
      assert (cmd_q.is_data ? d_req : i_req);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [24:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [1:0]  d_oplen = 2'd0;
  logic [24:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_enable;
  logic        mem_ready = 1'b1;
  logic        mem_is_data;
  logic        mem_rw;
  logic [1:0]  mem_oplen;
  logic [24:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W          (25),
    .DATA_W          (32),
    .TIMEOUT_CYCLES  (TMO),
    .MAX_DATA_STREAK (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_ack       (i_ack),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_rw        (d_rw),
    .d_oplen     (d_oplen),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata),
    .err         (err),
    .mem_enable  (mem_enable),
    .mem_ready   (mem_ready),
    .mem_is_data (mem_is_data),
    .mem_rw      (mem_rw),
    .mem_oplen   (mem_oplen),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  int          tests = 0;
  int          fails = 0;
  int          busy_len = 4;
  bit          hang = 1'b0;
  logic [31:0] rdata_val = '0;
  bit          pending = 1'b0;
  int          cnt = 0;
  int          en_cnt = 0;
  bit          grants[$];

  // Controller model: accepts a strobe, drops ready the next cycle for busy_len cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ready = 1'b1;
      pending   = 1'b0;
      cnt       = 0;
    end else if (mem_enable) begin
      pending = 1'b1;
    end else if (pending) begin
      pending   = 1'b0;
      mem_ready = 1'b0;
      cnt       = busy_len;
    end else if (!mem_ready && !hang) begin
      if (cnt <= 1) begin
        mem_ready = 1'b1;
        mem_rdata = rdata_val;
      end else begin
        cnt--;
      end
    end
  end

  // Grant monitor
  always @(negedge clk) begin
    if (rst_n && mem_enable) begin
      en_cnt++;
      grants.push_back(mem_is_data);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (mem_enable) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input bit is_d, input int budget, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      n++;
      if (is_d ? d_ack : i_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit         ok;
    int         n;
    int         zeros;
    int         target;
    int         e0;
    logic [5:0] gv;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", {mem_enable, mem_is_data, mem_rw, mem_oplen, i_ack, d_ack, err}, 64'd0);
    check("rst_fields", {mem_addr, mem_wdata}, 64'd0);
    check("rst_rdata", {i_rdata, d_rdata}, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single fetch, 8 busy cycles, req held through its ack cycle
    busy_len  = 8;
    rdata_val = 32'h0010_0093;
    i_addr    = 25'h0C;
    i_req     = 1'b1;
    wait_en(10, ok);
    check("t1_enable", ok, 1);
    check("t1_addr", mem_addr, 64'h0C);
    check("t1_is_data", mem_is_data, 0);
    check("t1_cmd", {mem_rw, mem_oplen, mem_wdata}, {1'b0, 2'd2, 32'h0});
    wait_ack(1'b0, 40, ok, n);
    check("t1_ack", ok, 1);
    check("t1_latency", n, 10);
    check("t1_rdata", i_rdata, 64'h0010_0093);
    check("t1_err", err, 0);
    step();
    i_req = 1'b0;
    repeat (5) step();
    check("t1_one_enable", en_cnt, 1);

    // Simultaneous requests: data first, then instr
    busy_len  = 3;
    rdata_val = 32'h1111_2222;
    d_rw      = 1'b1;
    d_oplen   = 2'd2;
    d_addr    = 25'h40;
    d_wdata   = 32'h21;
    d_req     = 1'b1;
    i_addr    = 25'h10;
    i_req     = 1'b1;
    wait_en(10, ok);
    check("t2_enable_d", ok, 1);
    check("t2_first_is_data", mem_is_data, 1);
    check("t2_d_addr", mem_addr, 64'h40);
    check("t2_d_rw_wdata", {mem_rw, mem_wdata}, {1'b1, 32'h21});
    wait_ack(1'b1, 30, ok, n);
    check("t2_d_ack", ok, 1);
    step();
    d_req = 1'b0;
    wait_en(10, ok);
    check("t2_enable_i", ok, 1);
    check("t2_second_is_data", mem_is_data, 0);
    check("t2_i_addr", mem_addr, 64'h10);
    check("t2_i_rw_wdata", {mem_rw, mem_wdata}, 64'd0);
    wait_ack(1'b0, 30, ok, n);
    check("t2_i_ack", ok, 1);
    check("t2_i_rdata", i_rdata, 64'h1111_2222);
    step();
    i_req = 1'b0;
    step();

    // Continuous data traffic with instr pending
`ifdef ARB_FAIR_EN
    target = 6;
`else
    target = 20;
`endif
    grants.delete();
    busy_len  = 1;
    rdata_val = 32'hA5A5_0001;
    d_rw      = 1'b0;
    d_addr    = 25'h80;
    d_wdata   = '0;
    d_req     = 1'b1;
    i_addr    = 25'h20;
    i_req     = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if ((i_ack || d_ack) && grants.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check("t3_done", ok, 1);
    check("t3_last_rdata", d_rdata, 64'hA5A5_0001);
    step();
    d_req = 1'b0;
    i_req = 1'b0;
`ifdef ARB_FAIR_EN
    for (int k = 0; k < 6; k++) gv[k] = (grants.size() > k) ? grants[k] : 1'bx;
    check("t3_fair_seq", gv, 6'b101111);
`else
    zeros = 0;
    for (int k = 0; k < 20; k++) if (grants.size() > k && !grants[k]) zeros++;
    check("t3_instr_grants", zeros, 0);
    check("t3_grant_count", grants.size(), 20);
`endif
    step();

    // Hung controller: timeout with err and zero data
    hang   = 1'b1;
    d_rw   = 1'b0;
    d_addr = 25'h44;
    d_req  = 1'b1;
    wait_en(10, ok);
    check("t4_enable", ok, 1);
    wait_ack(1'b1, 60, ok, n);
    check("t4_ack", ok, 1);
    check("t4_latency", n, TMO + 1);
    check("t4_err", err, 1);
    check("t4_rdata", d_rdata, 64'd0);
    step();
    d_req = 1'b0;
    @(negedge clk);
    check("t4_err_pulse", {err, d_ack}, 64'd0);
    hang = 1'b0;

    // Arbiter back in IDLE: a fresh fetch completes normally
    busy_len  = 2;
    rdata_val = 32'h0BAD_F00D;
    i_addr    = 25'h24;
    step();
    i_req = 1'b1;
    wait_en(20, ok);
    check("t4_recover_enable", ok, 1);
    wait_ack(1'b0, 30, ok, n);
    check("t4_recover_ack", ok, 1);
    check("t4_recover_data", {err, i_rdata}, {1'b0, 32'h0BAD_F00D});
    step();
    i_req = 1'b0;
    step();

    // Reset in the middle of BUSY
    hang    = 1'b1;
    d_rw    = 1'b1;
    d_addr  = 25'h48;
    d_wdata = 32'h55;
    d_req   = 1'b1;
    wait_en(10, ok);
    check("t5_enable", ok, 1);
    repeat (3) @(negedge clk);
    step();
    rst_n = 1'b0;
    d_req = 1'b0;
    hang  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_rst_ctl", {mem_enable, mem_is_data, mem_rw, mem_oplen, i_ack, d_ack, err}, 64'd0);
    check("t5_rst_fields", {mem_addr, mem_wdata}, 64'd0);
    check("t5_rst_rdata", {i_rdata, d_rdata}, 64'd0);
    e0 = en_cnt;
    n  = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (i_ack || d_ack || err) n++;
    end
    check("t5_no_ack", n, 0);
    step();
    check("t5_no_enable", en_cnt - e0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
